counter_ud_prescaled: RTL and testbench

COUNTER_UD_PRESCALED -- requirements
Module: counter_ud_prescaled

---
 rtl/counter_ud_prescaled_pkg.sv | 22 ++
 rtl/counter_ud_prescaled_if.sv | 18 +
 rtl/counter_ud_prescaled_tick_gen.sv | 43 ++++
 rtl/counter_ud_prescaled.sv | 78 +++++++
 tb/tb_counter_ud_prescaled.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/counter_ud_prescaled_pkg.sv
// Shared counter constants: boundary modes and prescaler sizing helpers,
// reused by every timer block that instantiates tick_gen.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Clock cycles per tick; a zero or sub-unity ratio collapses to 1 so the
  // prescaler always has a legal period.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    int unsigned d;
    d = (tick_hz == 0) ? 1 : clk_hz / tick_hz;
    if (d == 0) d = 1;
    return d;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/counter_ud_prescaled_if.sv
// Signal bundle around the prescaled up/down counter; used by the bench to
// group stimulus and observed outputs per counter instance.
interface counter_ud_prescaled_if #(
  parameter int unsigned WIDTH = 8
) ();
  // No handshake: ld is a single-cycle strobe; q/tc/tick are plain outputs
  // valid every cycle, with no ready/backpressure path.
  logic             ss;
  logic             ud;
  logic             ld;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tick;
  logic             tc;

  modport master (output ss, ud, ld, din, input q, tick, tc);
  modport slave  (input ss, ud, ld, din, output q, tick, tc);
endinterface

// File: rtl/counter_ud_prescaled_tick_gen.sv
// Reusable prescaler: counts 0..DIV-1 while enabled, strobes tick on the
// last count, holds while disabled and clears synchronously on clr.
module tick_gen
  import counter_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    CW   = cnt_width(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // With DIV=1 LAST is 0 and cnt_q never leaves 0, so tick follows en.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ud_prescaled.sv
// Prescaled up/down counter with load, wrap or saturate at [0, MAX_VAL],
// and a registered one-cycle terminal-count pulse.
module counter_ud_prescaled
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1,
  parameter int          MODE    = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             ss,
  input  logic             ud,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc
);

  localparam int unsigned      DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;
  logic             at_bound;

  // Load also clears the prescaler so a fresh full period follows it.
  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rs   (rs),
    .en   (ss),
    .clr  (ld),
    .tick (tick)
  );

  assign at_bound = ud ? (q_q == MAX_Q) : (q_q == '0);

  // Boundary is tested before stepping so no value ever leaves [0, MAX_VAL].
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (ld) begin
      q_d = (din > MAX_Q) ? MAX_Q : din;
    end else if (tick) begin
      tc_d = at_bound;
      if (at_bound) begin
        if (MODE == MODE_SAT) begin
          q_d = q_q;
        end else begin
          q_d = ud ? '0 : MAX_Q;
        end
      end else begin
        q_d = ud ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q  = q_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_counter_ud_prescaled.sv
// Directed bench: DIV=10 wrap and saturate counters with hand sequences,
// plus a DIV=1 counter driven from a per-cycle vector table.
module tb_counter_ud_prescaled;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic rs0, rs1, rs2;
  int   n_tests = 0;
  int   n_fail  = 0;

  counter_ud_prescaled_if #(.WIDTH(4)) if0 ();
  counter_ud_prescaled_if #(.WIDTH(4)) if1 ();
  counter_ud_prescaled_if #(.WIDTH(4)) if2 ();

  counter_ud_prescaled #(.WIDTH(4), .CLK_HZ(10), .TICK_HZ(1), .MAX_VAL(9), .MODE(MODE_WRAP)) u_wrap (
    .clk(clk), .rs(rs0), .ss(if0.ss), .ud(if0.ud), .ld(if0.ld), .din(if0.din),
    .q(if0.q), .tick(if0.tick), .tc(if0.tc));

  counter_ud_prescaled #(.WIDTH(4), .CLK_HZ(10), .TICK_HZ(1), .MAX_VAL(9), .MODE(MODE_SAT)) u_sat (
    .clk(clk), .rs(rs1), .ss(if1.ss), .ud(if1.ud), .ld(if1.ld), .din(if1.din),
    .q(if1.q), .tick(if1.tick), .tc(if1.tc));

  counter_ud_prescaled #(.WIDTH(4), .CLK_HZ(10), .TICK_HZ(10), .MAX_VAL(9), .MODE(MODE_WRAP)) u_div1 (
    .clk(clk), .rs(rs2), .ss(if2.ss), .ud(if2.ud), .ld(if2.ld), .din(if2.din),
    .q(if2.q), .tick(if2.tick), .tc(if2.tc));

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       ud;
    logic       ld;
    logic [3:0] din;
    logic [3:0] exp_q;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkv(input logic ss, input logic ud, input logic ld,
                               input int din, input int eq, input logic etc);
    vec_t v;
    v.ss = ss; v.ud = ud; v.ld = ld;
    v.din = 4'(din); v.exp_q = 4'(eq); v.exp_tc = etc;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drv0(input logic ss, input logic ud, input logic ld, input logic [3:0] din);
    if0.ss = ss; if0.ud = ud; if0.ld = ld; if0.din = din;
  endtask

  task automatic drv1(input logic ss, input logic ud, input logic ld, input logic [3:0] din);
    if1.ss = ss; if1.ud = ud; if1.ld = ld; if1.din = din;
  endtask

  task automatic drv2(input logic ss, input logic ud, input logic ld, input logic [3:0] din);
    if2.ss = ss; if2.ud = ud; if2.ld = ld; if2.din = din;
  endtask

  task automatic chk0(input string tag, input int eq, input int etick, input int etc);
    chk({tag, "_q"}, int'(if0.q), eq);
    chk({tag, "_tick"}, int'(if0.tick), etick);
    chk({tag, "_tc"}, int'(if0.tc), etc);
  endtask

  task automatic chk1(input string tag, input int eq, input int etick, input int etc);
    chk({tag, "_q"}, int'(if1.q), eq);
    chk({tag, "_tick"}, int'(if1.tick), etick);
    chk({tag, "_tc"}, int'(if1.tc), etc);
  endtask

  initial begin
    rs0 = 1'b1; rs1 = 1'b1; rs2 = 1'b1;
    drv0(1'b0, 1'b1, 1'b0, 4'd0);
    drv1(1'b0, 1'b0, 1'b0, 4'd0);
    drv2(1'b0, 1'b0, 1'b0, 4'd0);

    // DIV=1 table: one entry per clock, expected q/tc after that edge
    for (int i = 0; i < 9; i++) vecs[i] = mkv(1'b1, 1'b1, 1'b0, 0, i + 1, 1'b0);
    vecs[9]  = mkv(1'b1, 1'b1, 1'b0, 0,  0, 1'b1);
    vecs[10] = mkv(1'b0, 1'b1, 1'b0, 0,  0, 1'b0);
    vecs[11] = mkv(1'b1, 1'b0, 1'b0, 0,  9, 1'b1);
    vecs[12] = mkv(1'b1, 1'b0, 1'b0, 0,  8, 1'b0);
    vecs[13] = mkv(1'b1, 1'b0, 1'b1, 12, 9, 1'b0);
    vecs[14] = mkv(1'b0, 1'b0, 1'b1, 5,  5, 1'b0);
    vecs[15] = mkv(1'b1, 1'b1, 1'b0, 0,  6, 1'b0);
    vecs[16] = mkv(1'b0, 1'b0, 1'b0, 0,  6, 1'b0);

    #1 rs0 = 1'b0; rs1 = 1'b0; rs2 = 1'b0;
    #1 chk0("reset", 0, 0, 0);
    repeat (2) cyc();

    // Wrap counter: release and count up through a full 0..9..0 cycle
    rs0 = 1'b1;
    drv0(1'b1, 1'b1, 1'b0, 4'd0);
    for (int t = 1; t <= 101; t++) begin
      cyc();
      chk0("upcount", (t / 10) % 10, int'(t % 10 == 9), int'(t == 100));
    end

    // Pause at prescaler=4 for 7 clocks, then resume
    repeat (3) cyc();
    if0.ss = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk0("paused", 0, 0, 0);
    end
    if0.ss = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      chk0("resume", (k >= 6) ? 1 : 0, int'(k == 5 || k == 15), 0);
    end

    // Load 15 on a tick cycle: clamped to 9, tick discarded
    chk("ld_tick_cycle", int'(if0.tick), 1);
    drv0(1'b1, 1'b1, 1'b1, 4'd15);
    cyc();
    chk0("ld_clamp", 9, 0, 0);
    if0.ld = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      cyc();
      chk0("after_ld", (k >= 10) ? 0 : 9, int'(k == 9), int'(k == 10));
    end

    // Down count from 3; ud toggled mid-period must not matter
    drv0(1'b1, 1'b0, 1'b1, 4'd3);
    cyc();
    chk0("ld3", 3, 0, 0);
    if0.ld = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk0("ud_mid", (k < 10) ? 3 : ((k < 20) ? 2 : 1), int'(k == 9 || k == 19), 0);
      if (k == 12) if0.ud = 1'b1;
      if (k == 18) if0.ud = 1'b0;
    end

    // Down wrap 0 -> 9, then async reset while tc is high
    drv0(1'b1, 1'b0, 1'b1, 4'd0);
    cyc();
    chk0("ld0", 0, 0, 0);
    if0.ld = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk0("dnwrap", (k == 10) ? 9 : 0, int'(k == 9), int'(k == 10));
    end
    #3 rs0 = 1'b0;
    #1 chk0("rst_tc", 0, 0, 0);
    cyc();
    chk0("rst_hold", 0, 0, 0);
    rs0 = 1'b1;

    // Reset mid-period with q=6
    drv0(1'b1, 1'b1, 1'b1, 4'd6);
    cyc();
    chk0("ld6", 6, 0, 0);
    if0.ld = 1'b0;
    repeat (4) cyc();
    chk0("pre_rst", 6, 0, 0);
    #3 rs0 = 1'b0;
    #1 chk0("rst_mid", 0, 0, 0);
    cyc();
    chk0("rst_mid_hold", 0, 0, 0);
    rs0 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk0("post_rst", (k == 10) ? 1 : 0, int'(k == 9), 0);
    end

    // Saturating counter: down at 0 holds, tc per tick; then up once
    rs1 = 1'b1;
    drv1(1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk1("sat_lo", 0, int'(k % 10 == 9), int'(k == 10 || k == 20));
    end
    if1.ud = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk1("sat_up", (k == 10) ? 1 : 0, int'(k == 9), 0);
    end
    drv1(1'b1, 1'b1, 1'b1, 4'd9);
    cyc();
    chk1("sat_ld9", 9, 0, 0);
    if1.ld = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk1("sat_hi", 9, int'(k == 9), int'(k == 10));
    end
    if1.ud = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk1("sat_dn", (k == 10) ? 8 : 9, int'(k == 9), 0);
    end

    // DIV=1 counter from the vector table
    rs2 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drv2(vecs[i].ss, vecs[i].ud, vecs[i].ld, vecs[i].din);
      #1;
      chk($sformatf("div1_tick[%0d]", i), int'(if2.tick), int'(vecs[i].ss));
      cyc();
      chk($sformatf("div1_q[%0d]", i), int'(if2.q), int'(vecs[i].exp_q));
      chk($sformatf("div1_tc[%0d]", i), int'(if2.tc), int'(vecs[i].exp_tc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
